// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, instruction-memory address, IF/ID register,
// and end-of-program detection with a drain period before raising o_halted.
module fetch_stage #(
  parameter int              XLEN         = 32,
  parameter int              IMEM_WORDS   = 256,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              DRAIN_CYCLES = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_ifid_valid,
  output logic [XLEN-1:0] o_ifid_pc,
  output logic [31:0]     o_ifid_instr,
  output logic [XLEN-1:0] o_ifid_pc_plus4,
  output logic [31:0]     o_fetch_count,
  output logic            o_halted
);

  // state   | meaning
  // S_RUN   | fetching, issuing one instruction per unstalled cycle
  // S_DRAIN | end of program seen, waiting for downstream stages to retire
  // S_HALT  | program finished; only reset leaves this state
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  localparam logic [31:0]     NOP      = 32'h0000_0013;
  localparam int              CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [XLEN:0]   PC_LIMIT = (XLEN+1)'(4 * IMEM_WORDS);

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [CNT_W-1:0]  r_drain_cnt;
  logic              r_ifid_valid;
  logic [XLEN-1:0]   r_ifid_pc;
  logic [31:0]       r_ifid_instr;
  logic [XLEN-1:0]   r_ifid_pc_plus4;
  logic [31:0]       r_fetch_count;
  logic              r_halted;

  logic              w_end;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_pc_plus4;
  logic              w_unused_rpc_lsb;

  // Out-of-range PC ends the program regardless of what memory returns.
  assign w_end            = ({1'b0, r_pc} >= PC_LIMIT) || (i_imem_rdata == 32'h0);
  assign w_target         = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign w_pc_plus4       = r_pc + XLEN'(4);
  assign w_unused_rpc_lsb = ^i_redirect_pc[1:0];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state         <= S_RUN;
      r_pc            <= RESET_PC;
      r_drain_cnt     <= '0;
      r_ifid_valid    <= 1'b0;
      r_ifid_pc       <= '0;
      r_ifid_instr    <= NOP;
      r_ifid_pc_plus4 <= '0;
      r_fetch_count   <= '0;
      r_halted        <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_redirect_valid) begin
            r_pc         <= w_target;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP;
          end else if (!i_stall) begin
            if (w_end) begin
              // The terminating word is never issued downstream.
              r_ifid_valid <= 1'b0;
              r_ifid_instr <= NOP;
              r_drain_cnt  <= '0;
              r_state      <= S_DRAIN;
            end else begin
              r_ifid_valid    <= 1'b1;
              r_ifid_pc       <= r_pc;
              r_ifid_instr    <= i_imem_rdata;
              r_ifid_pc_plus4 <= w_pc_plus4;
              r_pc            <= w_pc_plus4;
              r_fetch_count   <= r_fetch_count + 32'd1;
            end
          end
        end
        S_DRAIN: begin
          r_ifid_valid <= 1'b0;
          if (i_redirect_valid) begin
            // An older branch resolved taken: the end word was wrong-path.
            r_pc        <= w_target;
            r_drain_cnt <= '0;
            r_state     <= S_RUN;
          end else if (!i_stall) begin
            if (r_drain_cnt == CNT_LAST) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt + CNT_W'(1);
            end
          end
        end
        S_HALT: begin
          r_ifid_valid <= 1'b0;
          r_halted     <= 1'b1;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign o_imem_addr     = r_pc;
  assign o_ifid_valid    = r_ifid_valid;
  assign o_ifid_pc       = r_ifid_pc;
  assign o_ifid_instr    = r_ifid_instr;
  assign o_ifid_pc_plus4 = r_ifid_pc_plus4;
  assign o_fetch_count   = r_fetch_count;
  assign o_halted        = r_halted;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end for the pipelined RV32I core. It holds the PC, drives the instruction-memory address, and registers {pc, instruction, pc+4} into the IF/ID pipeline register for decode. It also detects end-of-program (zero instruction word or PC beyond memory). After the pipeline drains it raises `halted`, which top-level benches use as the stop condition.

Parameters:
XLEN, 32, datapath/PC width
IMEM_WORDS, 256, instruction memory depth in 32-bit words; valid PCs are 0 .. 4*IMEM_WORDS-4
RESET_PC, 32'h0000_0000, PC loaded on reset
DRAIN_CYCLES, 4, cycles to wait after end-of-program so downstream stages (ID/EX/MEM/WB) retire

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
stall  in  1  hazard-unit stall; hold PC and IF/ID contents
redirect_valid  in  1  branch/jump taken, resolved in EX
redirect_pc  in  XLEN  target PC; bits [1:0] ignored (forced 0)
imem_addr  out  XLEN  byte address to instruction memory; combinational, equals pc
imem_rdata  in  32  instruction word; combinational read, same cycle as imem_addr
ifid_valid  out  1  IF/ID register holds a real instruction
ifid_pc  out  XLEN  PC of ifid_instr
ifid_instr  out  32  fetched instruction (32'h0000_0013 NOP when invalid)
ifid_pc_plus4  out  XLEN  ifid_pc + 4
fetch_count  out  32  number of instructions issued into IF/ID
halted  out  1  program finished and pipeline drained

Behaviour:
- Reset (reset==0, asynchronous):
  - pc = RESET_PC; state = RUN; ifid_valid = 0; ifid_pc = 0; ifid_instr = 32'h13; ifid_pc_plus4 = 0; fetch_count = 0; drain counter = 0; halted = 0.
  - Reset deasserts synchronously into RUN. Reset mid-drain or in HALT fully restarts the block.
- State machine has three states: RUN, DRAIN, HALT.
- end_cond = (imem_rdata == 32'h0) OR (pc >= 4*IMEM_WORDS). Out-of-range PC wins even if rdata is nonzero.
- RUN, per clock edge, evaluated in priority order:
  1. redirect_valid=1 (overrides stall): pc <= {redirect_pc[XLEN-1:2],2'b00}; ifid_valid <= 0; ifid_instr <= NOP. Flushes the wrong-path fetch.
  2. stall=1: pc and all ifid_* hold; fetch_count holds.
  3. end_cond=1: ifid_valid <= 0; ifid_instr <= NOP; pc holds; drain counter <= 0; state <= DRAIN. The zero word is never issued.
  4. Otherwise: ifid_valid <= 1; ifid_pc <= pc; ifid_instr <= imem_rdata; ifid_pc_plus4 <= pc+4; pc <= pc+4; fetch_count <= fetch_count+1.
- Arithmetic: pc+4 wraps modulo 2^XLEN. fetch_count wraps at 2^32.
- DRAIN:
  - ifid_valid stays 0.
  - redirect_valid=1: an older branch took, so the zero word was wrong-path. pc <= target; state <= RUN; counter cleared.
  - Otherwise, stall=0: counter += 1. When counter reaches DRAIN_CYCLES-1: state <= HALT, halted <= 1 (halted rises DRAIN_CYCLES cycles after DRAIN entry).
  - stall=1: counter holds.
- HALT:
  - halted=1; ifid_valid=0; pc frozen.
  - redirect_valid and stall are ignored. Only reset exits.
- imem_addr is always pc, including in DRAIN and HALT.
- Simultaneous redirect and end_cond in RUN: redirect wins and the block stays in RUN.
- Latency: instruction at PC p appears on ifid_* one cycle after pc==p with no stall.

Test Plan:
- Straight-line: imem[0..2] = 0x00500093, 0x00300113, 0x002081B3, imem[3] = 0. Release reset. Expect ifid_pc 0, 4, 8 on three consecutive cycles with ifid_valid=1, then ifid_valid=0. halted=1 exactly 4 cycles after DRAIN entry. fetch_count=3.
- Stall: assert stall for 2 cycles while ifid_pc=4. Expect ifid_pc/ifid_instr held at 4/0x00300113, imem_addr held at 8, and fetch_count unchanged. On release, ifid_pc=8 next cycle.
- Redirect: redirect_valid=1 with redirect_pc=0x23 while pc=0x10. Expect a bubble next cycle (ifid_valid=0) and imem_addr=0x20. The cycle after, ifid_pc=0x20.
- Redirect overrides stall and end_cond: same cycle, stall=1, imem_rdata=0, redirect_pc=0x40. Expect state RUN, pc=0x40, no DRAIN.
- Drain cancel: zero word at 0x0C. One cycle into DRAIN, redirect_pc=0x30. Expect halted stays 0, fetching resumes at 0x30, fetch_count continues incrementing.
- Out-of-range and reset: IMEM_WORDS=4 with all nonzero words. Expect DRAIN when pc=0x10, then halted=1. Drive reset low asynchronously mid-cycle. Expect halted=0, ifid_valid=0, imem_addr=0 immediately, with no clock edge needed.
